mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit with HI/LO registers, for the CPU pipeline EX stage.
- Handles MULT, MULTU, DIV and DIVU, which the single-cycle ALU does not implement.
- The EX stage issues an operation with a start/busy handshake.
- ID reads HI/LO for MFHI/MFLO, and the pipeline stalls while busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITERS, WIDTH, number of shift-add or restoring-divide iterations.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  issue request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  in  WIDTH  multiplicand or dividend (rs).
- B  in  WIDTH  multiplier or divisor (rt).
- hi_wr  in  1  MTHI write enable.
- lo_wr  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO are updated with a result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; hi=0, lo=0, busy=0, done=0; internal counters and operands cleared. Reset has priority over everything.
  - Reset mid-operation aborts the operation; no partial result is ever written.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Latch op, the magnitudes of A/B (signed ops) or raw A/B (unsigned ops), and the result-sign flags.
  - count=0; busy=1 after E0.
- CALC: one iteration per edge, E1..E32; count increments; after count reaches ITERS-1, go to FIX.
  - Multiply: 64-bit shift-add accumulator.
  - Divide: restoring algorithm; remainder/quotient shift pair.
- FIX, edge E33:
  - Apply sign correction and write hi/lo.
  - done=1 for exactly the cycle after E33; busy=0 after E33; return to IDLE.
- Latency: start accepted at E0; result visible on hi/lo, with done=1, after E33, i.e. 33 edges later.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product, signed or unsigned.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero, both signed and unsigned: lo=32'hFFFFFFFF, hi=A. Still takes the full 33 edges.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, with no trap.
  - Signed magnitude of 0x80000000 is taken as 33-bit unsigned internally, so there is no overflow in the iterations.
- Handshake:
  - start while busy=1 is ignored; the running operation is unaffected.
  - done is never asserted except after FIX.
- MTHI/MTLO:
  - hi_wr/lo_wr write wdata at the edge only in IDLE with start=0.
  - If start=1 in the same cycle, the write is dropped.
  - While busy, writes are ignored.
  - hi_wr and lo_wr together write both registers.
- hi/lo hold their value through CALC; they are only updated in FIX or by MTHI/MTLO.

Decomposition:
- Shared package (e.g. cpu_pkg) holds:
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - state encoding S_IDLE/S_CALC/S_FIX;
  - the ITERS default.
- One sub-module, md_step: purely combinational single iteration.
  - Inputs: accumulator/remainder, operand, mode.
  - Outputs: next accumulator and quotient bit.
  - Instantiated once and used every CALC cycle.
- FSM, sign handling and HI/LO registers live in mdu_iter.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=0x00000003 -> after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse 1 cycle, busy high for edges E1..E33.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU A=7, B=2 -> lo=3, hi=1.
- DIVU A=0x12345678, B=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue MULT 5*6, pulse start again at E10 with op=DIVU, then assert reset=0 at E20 of a third op -> first result hi=0, lo=30 at E33 with the second start ignored; after reset: hi=lo=0, busy=0, done=0, no done pulse.
- Idle, hi_wr=1, wdata=0xCAFEF00D -> hi updates next edge. hi_wr=1 with start=1 same cycle -> write dropped. lo_wr=1 while busy -> lo unchanged.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared op/state encodings and iteration default for the multiply/divide unit
package mdu_iter_pkg;
  typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11} md_op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_CALC = 2'b01, S_FIX = 2'b10} state_e;
  localparam int ITERS_DEF = 32;
endpackage

// File: rtl/mdu_iter_step.sv
// md_step: one combinational shift-add (multiply) or restoring-divide iteration
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opd_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_o
);
  logic [WIDTH:0] sum, rem_sh, diff;
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opd_i} : '0);
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opd_i};
    q_o    = div_i & ~diff[WIDTH];
    // divide leaves the quotient bit slot clear; the caller merges q_o into it
    acc_o  = div_i ? {q_o ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0}
                   : {sum, acc_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and start/busy handshake
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = ITERS_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_wr_i,
  input  logic             lo_wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(ITERS);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
  logic [WIDTH-1:0] opd_q, opd_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, quo, rem;
  logic div_q, div_d, nq_q, nq_d, nr_q, nr_d, dz_q, dz_d, done_q, done_d, q_bit, sgn;

  md_step #(.WIDTH(WIDTH)) u_step (.acc_i(acc_q), .opd_i(opd_q), .div_i(div_q), .acc_o(step_acc), .q_o(q_bit));

  always_comb begin
    sgn     = ~op_i[0];
    a_mag   = (sgn & a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag   = (sgn & b_i[WIDTH-1]) ? -b_i : b_i;
    prod    = nq_q ? -acc_q : acc_q;
    quo     = nq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem     = nr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    div_d   = div_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (start_i) begin
        state_d = S_CALC;
        cnt_d   = '0;
        div_d   = op_i[1];
        nq_d    = sgn & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        nr_d    = sgn & op_i[1] & a_i[WIDTH-1];
        dz_d    = op_i[1] & (b_i == '0);
        // multiply shifts the multiplier out of the low half; divide shifts the dividend in
        acc_d   = {{WIDTH{1'b0}}, op_i[1] ? a_mag : b_mag};
        opd_d   = op_i[1] ? b_mag : a_mag;
      end else begin
        hi_d = hi_wr_i ? wdata_i : hi_q;
        lo_d = lo_wr_i ? wdata_i : lo_q;
      end
    end else if (state_q == S_CALC) begin
      acc_d   = step_acc | {{(2*WIDTH-1){1'b0}}, q_bit};
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(ITERS-1)) ? S_FIX : S_CALC;
    end else begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d    = div_q ? (dz_q ? '1 : quo) : prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      div_q   <= 1'b0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      div_q   <= div_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized and directed checks of mdu_iter against an arithmetic reference model
module tb_mdu_iter;
  import mdu_iter_pkg::*;
  logic clk = 1'b0, reset, start, hi_wr, lo_wr, busy, done;
  logic [1:0] op;
  logic [31:0] a, b, wdata, hi, lo;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  int checks = 0, errors = 0;

  mdu_iter dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .hi_wr_i(hi_wr), .lo_wr_i(lo_wr), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {hi, lo} the architecture requires for each op
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o[1] && y == 32'd0) return {x, 32'hFFFFFFFF};
    if (o == MD_MULT) return 64'(sx * sy);
    if (o == MD_MULTU) return {32'd0, x} * {32'd0, y};
    if (o == MD_DIV) return {32'(sx % sy), 32'(sx / sy)};
    return {x % y, x / y};
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int pulse_at, input int rst_at, input int mtlo_at);
    logic [63:0] r;
    logic busy_ok, hold_ok, seen;
    r = model(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    busy_ok = busy & ~done;
    hold_ok = (hi === exp_hi) && (lo === exp_lo);
    for (int i = 1; i <= 33; i++) begin
      if (i == pulse_at) begin start = 1'b1; op = MD_DIVU; a = $urandom; b = $urandom; end
      if (i == mtlo_at) begin lo_wr = 1'b1; wdata = ~exp_lo; end
      if (i == rst_at) reset = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; lo_wr = 1'b0;
      if (rst_at != 0 && i == rst_at) begin
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_busy_done", {busy, done}, 2'b00);
        reset = 1'b1; exp_hi = '0; exp_lo = '0;
        seen = 1'b0;
        repeat (36) begin @(posedge clk); #1; seen |= done | busy; end
        chk("abort_no_done", seen, 1'b0);
        return;
      end
      if (i < 33) begin
        busy_ok &= busy & ~done;
        hold_ok &= (hi === exp_hi) && (lo === exp_lo);
      end
    end
    chk("busy_during_calc", busy_ok, 1'b1);
    chk("hilo_hold", hold_ok, 1'b1);
    chk("done_pulse", {done, busy}, 2'b10);
    chk($sformatf("result op%0d %h %h", o, x, y), {hi, lo}, r);
    {exp_hi, exp_lo} = r;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [1:0] o;
    reset = 1'b0; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0; op = '0; a = '0; b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {busy, done}, 2'b00);
    reset = 1'b1;
    run_op(MD_MULT, 32'hFFFFFFFE, 32'h3, 0, 0, 0);
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    run_op(MD_DIV, 32'hFFFFFFF9, 32'h2, 0, 0, 0);
    run_op(MD_DIVU, 32'd7, 32'd2, 0, 0, 0);
    run_op(MD_DIVU, 32'h12345678, 32'h0, 0, 0, 0);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
    run_op(MD_DIV, 32'h80000000, 32'h0, 0, 0, 0);
    run_op(MD_MULT, 32'd5, 32'd6, 10, 0, 0);
    hi_wr = 1'b1; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    hi_wr = 1'b0; exp_hi = 32'hCAFEF00D;
    chk("mthi_idle", {hi, lo}, {exp_hi, exp_lo});
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h13572468;
    @(posedge clk); #1;
    hi_wr = 1'b0; lo_wr = 1'b0; exp_hi = 32'h13572468; exp_lo = 32'h13572468;
    chk("mthi_mtlo_both", {hi, lo}, {exp_hi, exp_lo});
    hi_wr = 1'b1; wdata = 32'h11111111;
    run_op(MD_DIVU, 32'd100, 32'd7, 0, 0, 5);
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: y = 32'hFFFFFFFF;
        2: y = 32'($urandom_range(1, 255));
        default: y = $urandom;
      endcase
      run_op(o, x, y, 0, 0, 0);
    end
    run_op(MD_MULT, 32'd123, 32'd456, 0, 20, 0);
    run_op(MD_DIV, 32'hFFFFFF00, 32'd16, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
